ram_arbiter: RTL and testbench

Shares the single-port data RAM between two requesters: port 0 is the CPU MEM stage and port 1 is the program loader/debug port. Each cycle, the arbiter picks at most one winner and drives the RAM address, write data and write enable from it. It routes synchronous read data back to the winner one cycle later. Port 0 has fixed priority; a wait counter guarantees port 1 forward progress. `m0_gnt` low is used by the stage controller as the MEM-stage stall.

---
 rtl/ram_arbiter.sv | 62 ++++++
 tb/tb_ram_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: fixed-priority two-port RAM arbiter with starvation guard; ports m0_*/m1_* requesters, ram_* RAM side, busy = read outstanding
module ram_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);
  localparam logic [3:0] MW = 4'(MAX_WAIT);
  logic [3:0] wait_cnt;
  logic       force1, rd_pend, rd_port;
  always_comb begin
    m1_gnt    = m1_req & (force1 | ~m0_req);
    m0_gnt    = m0_req & ~m1_gnt;
    ram_addr  = m1_gnt ? m1_addr : m0_addr;
    ram_wdata = m1_gnt ? m1_wdata : m0_wdata;
    ram_wren  = ~reset & (m1_gnt ? m1_we : (m0_gnt & m0_we));
    m0_rvalid = rd_pend & ~rd_port;
    m1_rvalid = rd_pend & rd_port;
    m0_rdata  = ram_rdata;
    m1_rdata  = ram_rdata;
    busy      = rd_pend;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      force1   <= 1'b0;
      rd_pend  <= 1'b0;
      rd_port  <= 1'b0;
    end else begin
      rd_pend <= (m0_gnt & ~m0_we) | (m1_gnt & ~m1_we);
      if ((m0_gnt & ~m0_we) | (m1_gnt & ~m1_we)) rd_port <= m1_gnt;
      if (m1_req & ~m1_gnt) begin
        wait_cnt <= (wait_cnt == MW) ? wait_cnt : wait_cnt + 4'd1;
        if (wait_cnt + 4'd1 == MW) force1 <= 1'b1;
      end else begin
        wait_cnt <= '0;
        if (m1_gnt) force1 <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed-vector bench for ram_arbiter with a synchronous RAM model
module tb_ram_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [15:0] m0_addr = 0, m1_addr = 0;
  logic [31:0] m0_wdata = 0, m1_wdata = 0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, ram_wren, busy;
  logic [31:0] m0_rdata, m1_rdata, ram_wdata, ram_rdata;
  logic [15:0] ram_addr;
  logic [31:0] mem [0:255];
  int n_vec = 0, n_err = 0;
  ram_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren),
    .ram_rdata(ram_rdata), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr[7:0]] <= ram_wdata;
    ram_rdata <= mem[ram_addr[7:0]];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[16] = 32'hDEADBEEF;
    mem[1]  = 32'hA0A0A0A1;
    mem[2]  = 32'hB0B0B0B2;
    m0_req = 1; m0_we = 1; m0_addr = 16'h0030;
    step(); step();
    chk("rst_wren", ram_wren, 0);
    chk("rst_gnt0", m0_gnt, 1);
    chk("rst_rv", {m0_rvalid, m1_rvalid, busy}, 0);
    chk("rst_wcnt", dut.wait_cnt, 0);
    m0_req = 0; m0_we = 0; reset = 0;
    step();
    m0_req = 1; m0_we = 0; m0_addr = 16'h0010;
    #1;
    chk("rd_gnt", {m0_gnt, m1_gnt}, 2'b10);
    chk("rd_addr", ram_addr, 16'h0010);
    chk("rd_wren", ram_wren, 0);
    chk("rd_busy0", busy, 0);
    step();
    m0_req = 0;
    chk("rd_rv0", m0_rvalid, 1);
    chk("rd_data", m0_rdata, 32'hDEADBEEF);
    chk("rd_rv1", m1_rvalid, 0);
    chk("rd_busy1", busy, 1);
    step();
    chk("rd_busy2", {busy, m0_rvalid}, 0);
    m1_req = 1; m1_we = 1; m1_addr = 16'h0004; m1_wdata = 32'h12345678;
    #1;
    chk("wr_gnt", {m0_gnt, m1_gnt}, 2'b01);
    chk("wr_wren", ram_wren, 1);
    chk("wr_wdata", ram_wdata, 32'h12345678);
    step();
    m1_req = 0; m1_we = 0;
    m0_req = 1; m0_addr = 16'h0004;
    #1;
    chk("wr_norv", {m0_rvalid, m1_rvalid}, 0);
    chk("wr_gnt0", m0_gnt, 1);
    step();
    m0_req = 0;
    chk("wr_rv0", m0_rvalid, 1);
    chk("wr_rdata", m0_rdata, 32'h12345678);
    step();
    m0_req = 1; m0_addr = 16'h0010; m1_req = 1; m1_addr = 16'h0004;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("cont_g0_c%0d", c), m0_gnt, c != 4);
      chk($sformatf("cont_g1_c%0d", c), m1_gnt, c == 4);
      if (c == 5) begin
        chk("cont_rv1", m1_rvalid, 1);
        chk("cont_data1", m1_rdata, 32'h12345678);
        chk("cont_wcnt", dut.wait_cnt, 0);
      end
      step();
    end
    m0_req = 0; m1_req = 0;
    step(); step();
    m0_req = 1; m0_addr = 16'h0001;
    #1;
    chk("b2b_wren0", ram_wren, 0);
    step();
    m0_req = 0; m1_req = 1; m1_addr = 16'h0002;
    chk("b2b_rv_c1", {m0_rvalid, m1_rvalid}, 2'b10);
    chk("b2b_data_c1", m0_rdata, 32'hA0A0A0A1);
    #1;
    chk("b2b_gnt_c1", {m0_gnt, m1_gnt, ram_wren}, 3'b010);
    step();
    m1_req = 0; m0_req = 1; m0_we = 1; m0_addr = 16'h0003; m0_wdata = 32'h0BADF00D;
    chk("b2b_rv_c2", {m0_rvalid, m1_rvalid}, 2'b01);
    chk("b2b_data_c2", m1_rdata, 32'hB0B0B0B2);
    #1;
    chk("b2b_wren_c2", {m0_gnt, ram_wren}, 2'b11);
    step();
    m0_req = 0; m0_we = 0;
    #1;
    chk("b2b_c3", {m0_rvalid, m1_rvalid, ram_wren, busy}, 0);
    chk("b2b_mem3", mem[3], 32'h0BADF00D);
    step();
    m0_req = 1; m0_addr = 16'h0010; m1_req = 1;
    step(); step(); step();
    #1;
    chk("rst_mid_gnt", m0_gnt, 1);
    #2 reset = 1;
    #1;
    chk("rst_mid_wren", ram_wren, 0);
    step();
    reset = 0;
    chk("rst_mid_rv", {m0_rvalid, m1_rvalid, busy}, 0);
    chk("rst_mid_wcnt", dut.wait_cnt, 0);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("rst_cont_c%0d", c), {m0_gnt, m1_gnt}, (c == 4) ? 2'b01 : 2'b10);
      step();
    end
    m0_req = 0; m1_req = 0;
    step();
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("idle_c%0d", c), {m0_gnt, m1_gnt, ram_wren, busy}, 0);
      chk($sformatf("idle_wcnt_c%0d", c), dut.wait_cnt, 0);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
